// File: rtl/alu_pkg.sv
// Shared types and constants for the 6-bit signed ALU operand path.
//   entry_state_t : operand entry FSM states
//   entry_mag()   : tens/ones digits -> unsigned 6-bit magnitude (max 39)
package alu_pkg;

  localparam int unsigned WIDTH       = 6;
  localparam int unsigned MAX_POS_MAG = 31;
  localparam int unsigned MAX_NEG_MAG = 32;
  localparam int unsigned TENS_MAX    = 3;
  localparam int unsigned ONES_MAX    = 9;

  typedef enum logic [1:0] {
    EDIT   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } entry_state_t;

  // Decimal digits to binary magnitude; 3*10+9 = 39 always fits in 6 bits.
  function automatic logic [WIDTH-1:0] entry_mag(input logic [1:0] tens,
                                                 input logic [3:0] ones);
    return WIDTH'(tens) * WIDTH'(10) + WIDTH'(ones);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, press pulse.
//   CLK, RESET_N : clock, async active-low reset
//   RAW          : raw asynchronous button level
//   LEVEL        : debounced level
//   PRESS        : one-cycle pulse on each debounced 0->1 transition
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Level follows the synchronized input only after an unbroken run of
  // DEBOUNCE_CYCLES disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      cnt     <= '0;
      LEVEL   <= 1'b0;
      level_d <= 1'b0;
      PRESS   <= 1'b0;
    end else begin
      meta <= RAW;
      sync <= meta;
      if (sync != LEVEL) begin
        if (cnt == CNT_LAST) begin
          LEVEL <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      level_d <= LEVEL;
      PRESS   <= LEVEL & ~level_d;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Interactive sign + two-digit decimal operand entry for the 6-bit signed ALU.
//   CLK, RESET_N                          : clock, async active-low reset
//   BTN_DIGIT/BTN_SEL/BTN_SIGN/BTN_ENTER  : raw push-buttons
//   VALUE      : last committed operand (two's complement)
//   VALID      : one-cycle pulse when VALUE updates
//   ERROR      : one-cycle pulse when ENTER is rejected (out of range)
//   ENTRY_TENS, ENTRY_ONES, ENTRY_NEG, SEL_TENS : live editing state
module operand_entry
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             BTN_DIGIT,
  input  logic             BTN_SEL,
  input  logic             BTN_SIGN,
  input  logic             BTN_ENTER,
  output logic [WIDTH-1:0] VALUE,
  output logic             VALID,
  output logic             ERROR,
  output logic [1:0]       ENTRY_TENS,
  output logic [3:0]       ENTRY_ONES,
  output logic             ENTRY_NEG,
  output logic             SEL_TENS
);

  logic digit_p;
  logic sel_p;
  logic sign_p;
  logic enter_p;
  // Debounced levels are not needed here; only the press pulses are used.
  logic [3:0] level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_digit (
    .CLK(CLK), .RESET_N(RESET_N), .RAW(BTN_DIGIT), .LEVEL(level_unused[0]), .PRESS(digit_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .CLK(CLK), .RESET_N(RESET_N), .RAW(BTN_SEL), .LEVEL(level_unused[1]), .PRESS(sel_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sign (
    .CLK(CLK), .RESET_N(RESET_N), .RAW(BTN_SIGN), .LEVEL(level_unused[2]), .PRESS(sign_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .CLK(CLK), .RESET_N(RESET_N), .RAW(BTN_ENTER), .LEVEL(level_unused[3]), .PRESS(enter_p)
  );

  entry_state_t     state;
  entry_state_t     state_nxt;
  logic [WIDTH-1:0] value_nxt;
  logic             valid_nxt;
  logic             error_nxt;
  logic [1:0]       tens_nxt;
  logic [3:0]       ones_nxt;
  logic             neg_nxt;
  logic             sel_nxt;
  logic [WIDTH-1:0] mag;
  logic             legal;

  assign mag   = entry_mag(ENTRY_TENS, ENTRY_ONES);
  assign legal = ENTRY_NEG ? (mag <= WIDTH'(MAX_NEG_MAG)) : (mag <= WIDTH'(MAX_POS_MAG));

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= EDIT;
      VALUE      <= '0;
      VALID      <= 1'b0;
      ERROR      <= 1'b0;
      ENTRY_TENS <= '0;
      ENTRY_ONES <= '0;
      ENTRY_NEG  <= 1'b0;
      SEL_TENS   <= 1'b0;
    end else begin
      state      <= state_nxt;
      VALUE      <= value_nxt;
      VALID      <= valid_nxt;
      ERROR      <= error_nxt;
      ENTRY_TENS <= tens_nxt;
      ENTRY_ONES <= ones_nxt;
      ENTRY_NEG  <= neg_nxt;
      SEL_TENS   <= sel_nxt;
    end
  end

  // Next-state and next-output logic; presses outside EDIT are dropped.
  always_comb begin
    state_nxt = state;
    value_nxt = VALUE;
    valid_nxt = 1'b0;
    error_nxt = 1'b0;
    tens_nxt  = ENTRY_TENS;
    ones_nxt  = ENTRY_ONES;
    neg_nxt   = ENTRY_NEG;
    sel_nxt   = SEL_TENS;

    case (state)
      EDIT: begin
        // One press per cycle: ENTER > SIGN > SEL > DIGIT.
        if (enter_p) begin
          state_nxt = CHECK;
        end else if (sign_p) begin
          neg_nxt = ~ENTRY_NEG;
        end else if (sel_p) begin
          sel_nxt = ~SEL_TENS;
        end else if (digit_p) begin
          if (SEL_TENS) begin
            tens_nxt = (ENTRY_TENS == 2'(TENS_MAX)) ? 2'd0 : ENTRY_TENS + 2'd1;
          end else begin
            ones_nxt = (ENTRY_ONES == 4'(ONES_MAX)) ? 4'd0 : ENTRY_ONES + 4'd1;
          end
        end
      end
      CHECK: begin
        if (legal) begin
          state_nxt = COMMIT;
        end else begin
          error_nxt = 1'b1;
          state_nxt = EDIT;
        end
      end
      COMMIT: begin
        // Negation wraps mod 64, so -0 lands on 0.
        value_nxt = ENTRY_NEG ? (~mag + WIDTH'(1)) : mag;
        valid_nxt = 1'b1;
        state_nxt = EDIT;
      end
      default: begin
        state_nxt = EDIT;
      end
    endcase
  end

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry with a 4-cycle debounce.
module tb_operand_entry;

  localparam int unsigned DB = 4;
  localparam int B_DIGIT = 0;
  localparam int B_SEL   = 1;
  localparam int B_SIGN  = 2;
  localparam int B_ENTER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_digit = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_sign = 1'b0;
  logic       btn_enter = 1'b0;
  logic [5:0] value;
  logic       valid;
  logic       error;
  logic [1:0] entry_tens;
  logic [3:0] entry_ones;
  logic       entry_neg;
  logic       sel_tens;

  operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .BTN_DIGIT(btn_digit), .BTN_SEL(btn_sel), .BTN_SIGN(btn_sign), .BTN_ENTER(btn_enter),
    .VALUE(value), .VALID(valid), .ERROR(error),
    .ENTRY_TENS(entry_tens), .ENTRY_ONES(entry_ones), .ENTRY_NEG(entry_neg), .SEL_TENS(sel_tens)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference entry state.
  int m_tens = 0;
  int m_ones = 0;
  int m_neg  = 0;
  int m_sel  = 0;

  typedef struct {
    bit err;
    int val;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int model_mag();
    return m_tens * 10 + m_ones;
  endfunction

  function automatic bit model_legal();
    return (m_neg != 0) ? (model_mag() <= 32) : (model_mag() <= 31);
  endfunction

  function automatic int model_value();
    if (m_neg != 0) return (64 - model_mag()) % 64;
    return model_mag();
  endfunction

  // Raw edge at cycle c -> ENTER pulse at c+7 -> ERROR at c+9 / VALID at c+10.
  task automatic push_enter(input int c);
    exp_t e;
    e.err = !model_legal();
    e.val = model_value();
    e.cyc = c + (e.err ? 9 : 10);
    sb.push_back(e);
  endtask

  task automatic model_apply(input int b);
    case (b)
      B_DIGIT: if (m_sel != 0) m_tens = (m_tens + 1) % 4; else m_ones = (m_ones + 1) % 10;
      B_SEL:   m_sel = 1 - m_sel;
      B_SIGN:  m_neg = 1 - m_neg;
      default: ;
    endcase
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_DIGIT: btn_digit = v;
      B_SEL:   btn_sel   = v;
      B_SIGN:  btn_sign  = v;
      default: btn_enter = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    @(negedge clk);
    set_btn(b, 1'b1);
    if (b == B_ENTER) push_enter(cyc);
    else model_apply(b);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (16) @(negedge clk);
  endtask

  task automatic check_entry(input string tag);
    check_eq({tag, "_tens"}, int'(entry_tens), m_tens);
    check_eq({tag, "_ones"}, int'(entry_ones), m_ones);
    check_eq({tag, "_neg"},  int'(entry_neg),  m_neg);
    check_eq({tag, "_sel"},  int'(sel_tens),   m_sel);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_value"}, int'(value), 0);
    check_eq({tag, "_valid"}, int'(valid), 0);
    check_eq({tag, "_error"}, int'(error), 0);
    check_entry(tag);
  endtask

  // Output monitor: every VALID/ERROR pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && error) check_eq("valid_error_exclusive", 1, 0);
      if (valid || error) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("pulse_kind_err", int'(error), int'(mon_e.err));
          check_eq("pulse_cycle", cyc, mon_e.cyc);
          if (valid) check_eq("commit_value", int'(value), mon_e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Entry -7.
    for (int i = 0; i < 7; i++) press(B_DIGIT, 8);
    press(B_SIGN, 8);
    check_entry("minus7_entry");
    press(B_ENTER, 8);

    // Async reset mid-cycle, DIGIT held through reset release.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    btn_digit = 1'b1;
    #1;
    m_tens = 0; m_ones = 0; m_neg = 0; m_sel = 0;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("held_digit_early", int'(entry_ones), 0);
    repeat (4) @(negedge clk);
    m_ones = 1;
    check_eq("held_digit_late", int'(entry_ones), 1);
    btn_digit = 1'b0;
    repeat (16) @(negedge clk);

    // -32: tens=3, ones=2, negative.
    press(B_DIGIT, 8);
    press(B_SEL, 8);
    for (int i = 0; i < 3; i++) press(B_DIGIT, 8);
    press(B_SIGN, 8);
    check_entry("minus32_entry");
    press(B_ENTER, 8);

    // +32 is rejected, VALUE holds -32.
    press(B_SIGN, 8);
    press(B_ENTER, 8);
    check_eq("hold_after_error", int'(value), 32);

    // +31.
    press(B_SEL, 8);
    for (int i = 0; i < 9; i++) press(B_DIGIT, 8);
    check_entry("plus31_entry");
    press(B_ENTER, 8);

    // Digit wrap-around.
    for (int i = 0; i < 10; i++) press(B_DIGIT, 8);
    check_eq("ones_wrap", int'(entry_ones), 1);
    press(B_SEL, 8);
    press(B_DIGIT, 8);
    check_eq("tens_wrap", int'(entry_tens), 0);
    for (int i = 0; i < 3; i++) press(B_DIGIT, 8);
    check_eq("tens_cycle", int'(entry_tens), 3);

    // Bounce shorter than the debounce window never registers.
    @(negedge clk);
    btn_digit = 1'b1;
    repeat (3) @(negedge clk);
    btn_digit = 1'b0;
    @(negedge clk);
    btn_digit = 1'b1;
    repeat (3) @(negedge clk);
    btn_digit = 1'b0;
    repeat (16) @(negedge clk);
    check_entry("bounce");
    press(B_DIGIT, 8);
    check_entry("clean_press");

    // SIGN and DIGIT aligned: SIGN wins.
    @(negedge clk);
    btn_sign = 1'b1;
    btn_digit = 1'b1;
    model_apply(B_SIGN);
    repeat (8) @(negedge clk);
    btn_sign = 1'b0;
    btn_digit = 1'b0;
    repeat (16) @(negedge clk);
    check_entry("simultaneous");

    // DIGIT pulse lands in CHECK and is dropped.
    @(negedge clk);
    btn_enter = 1'b1;
    push_enter(cyc);
    @(negedge clk);
    btn_digit = 1'b1;
    repeat (8) @(negedge clk);
    btn_enter = 1'b0;
    btn_digit = 1'b0;
    repeat (16) @(negedge clk);
    check_entry("digit_in_check");

    // Reset while in CHECK: no VALID or ERROR afterwards.
    @(negedge clk);
    c = cyc;
    btn_enter = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check_eq("reset_in_check_cycle", cyc, c + 8);
    rst_n = 1'b0;
    btn_enter = 1'b0;
    m_tens = 0; m_ones = 0; m_neg = 0; m_sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_zero("after_reset_in_check");

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check_eq("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
